// File: rtl/mem_pkg.sv
// Shared memory-side definitions: default bus widths used by the CPU, the RAM
// and the port arbiter, plus the arbiter state encoding.
package mem_pkg;

    localparam int MEM_ADDR_W = 14;
    localparam int MEM_DATA_W = 10;

    typedef enum logic {
        IDLE,
        WAIT
    } arb_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first pending channel found scanning
// upward from rr_ptr and wrapping past the top channel back to zero.
module rr_pick
    import mem_pkg::*;
#(
    parameter int N_RD  = 4,
    parameter int IDX_W = idx_w(N_RD)
) (
    input  logic [N_RD-1:0]  pending,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // The lowest pending channel is the wrap-around fallback; any pending
    // channel at or above rr_ptr overrides it, the lowest such one winning.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int j = N_RD - 1; j >= 0; j--) begin
            if (pending[j]) begin
                valid = 1'b1;
                idx   = IDX_W'(j);
            end
        end
        for (int j = N_RD - 1; j >= 0; j--) begin
            if (pending[j] && (j >= int'(rr_ptr))) begin
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one write and N_RD read channels from the CPU pipeline onto a
// single-port RAM; writes go first, reads rotate, stall holds the pipeline.
//
// state | meaning
// IDLE  | no RAM access in flight; issues the pending write, else a read
// WAIT  | read issued, counting down RAM_LAT before capturing ram_outdata
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int N_RD    = 4,
    parameter int RAM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic [N_RD-1:0]          rd_req,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_ready,
    output logic                     stall,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic                     ram_read,
    output logic                     ram_write,
    output logic [DATA_W-1:0]        ram_indata,
    input  logic [DATA_W-1:0]        ram_outdata
);

    localparam int IDX_W = idx_w(N_RD);
    localparam int LAT_W = idx_w(RAM_LAT);

    arb_state_t        state;
    logic              wr_served;
    logic [N_RD-1:0]   rd_served;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  cur;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rd_data_q [N_RD];
    logic [ADDR_W-1:0] rd_addr_a [N_RD];

    logic              wr_pend;
    logic [N_RD-1:0]   rd_pend;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic              issue_wr;
    logic              issue_rd;

    for (genvar i = 0; i < N_RD; i++) begin : g_chan
        assign rd_addr_a[i]                  = rd_addr[i*ADDR_W +: ADDR_W];
        assign rd_data[i*DATA_W +: DATA_W]   = rd_data_q[i];
    end

    assign wr_pend  = wr_req & ~wr_served;
    assign rd_pend  = rd_req & ~rd_served;
    assign stall    = wr_pend | (|rd_pend);
    assign wr_ready = wr_served;
    assign rd_ready = rd_served;

    rr_pick #(
        .N_RD  (N_RD),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .pending (rd_pend),
        .rr_ptr  (rr_ptr),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // Strobes are issued in the same cycle the request is seen so that a
    // bundle costs exactly one cycle per write and RAM_LAT+1 per read.
    assign issue_wr   = rst & (state == IDLE) & wr_pend;
    assign issue_rd   = rst & (state == IDLE) & ~wr_pend & pick_valid;
    assign ram_write  = issue_wr;
    assign ram_read   = issue_rd;
    assign ram_indata = issue_wr ? wr_data : '0;
    assign ram_addr   = issue_wr ? wr_addr :
                        issue_rd ? rd_addr_a[pick_idx] : addr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wr_served <= 1'b0;
            rd_served <= '0;
            rr_ptr    <= '0;
            cur       <= '0;
            lat_cnt   <= '0;
            addr_q    <= '0;
            for (int i = 0; i < N_RD; i++) begin
                rd_data_q[i] <= '0;
            end
        end else begin
            // stall low is the one cycle the pipeline advances: start a new bundle
            if (stall) begin
                wr_served <= wr_served & wr_req;
                rd_served <= rd_served & rd_req;
            end else begin
                wr_served <= 1'b0;
                rd_served <= '0;
            end

            case (state)
                IDLE: begin
                    if (issue_wr) begin
                        addr_q    <= wr_addr;
                        wr_served <= 1'b1;
                    end else if (issue_rd) begin
                        cur     <= pick_idx;
                        addr_q  <= rd_addr_a[pick_idx];
                        lat_cnt <= LAT_W'(RAM_LAT - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        // a channel that dropped its request mid-access gets nothing
                        if (rd_req[cur]) begin
                            rd_data_q[cur] <= ram_outdata;
                            rd_served[cur] <= 1'b1;
                        end
                        rr_ptr <= (cur == IDX_W'(N_RD - 1)) ? '0 : cur + 1'b1;
                        state  <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut1 (RAM_LAT=1) covers reset, single read and write-then-read;
// dut2 (RAM_LAT=2) covers rotation, fairness, abort and reset during WAIT.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int AW = 14;
    localparam int DW = 10;
    localparam int NR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst1, rst2;
    logic              wr_req;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NR-1:0]     rd_req;
    logic [NR*AW-1:0]  rd_addr;

    logic              wr_ready1, stall1, ram_read1, ram_write1;
    logic [NR*DW-1:0]  rd_data1;
    logic [NR-1:0]     rd_ready1;
    logic [AW-1:0]     ram_addr1;
    logic [DW-1:0]     ram_indata1, ram_outdata1;

    logic              wr_ready2, stall2, ram_read2, ram_write2;
    logic [NR*DW-1:0]  rd_data2;
    logic [NR-1:0]     rd_ready2;
    logic [AW-1:0]     ram_addr2;
    logic [DW-1:0]     ram_indata2, ram_outdata2;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_RD(NR), .RAM_LAT(1)) dut1 (
        .clk(clk), .rst(rst1), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready1), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_ready(rd_ready1), .stall(stall1), .ram_addr(ram_addr1), .ram_read(ram_read1),
        .ram_write(ram_write1), .ram_indata(ram_indata1), .ram_outdata(ram_outdata1)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_RD(NR), .RAM_LAT(2)) dut2 (
        .clk(clk), .rst(rst2), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready2), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data2),
        .rd_ready(rd_ready2), .stall(stall2), .ram_addr(ram_addr2), .ram_read(ram_read2),
        .ram_write(ram_write2), .ram_indata(ram_indata2), .ram_outdata(ram_outdata2)
    );

    // Background RAM contents: a fixed function of the address, overlaid by writes.
    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        int v;
        if (a == 14'h0040) return 10'h2A5;
        if (a == 14'h0100) return 10'h0AA;
        v = int'(a) * 13 + 5;
        return v[DW-1:0];
    endfunction

    function automatic logic [AW-1:0] chan_addr(input int ch);
        int v;
        v = 32'h200 + ch * 32'h11;
        return v[AW-1:0];
    endfunction

    bit            wr1 [1 << AW];
    logic [DW-1:0] wm1 [1 << AW];
    logic [DW-1:0] st1;
    bit            wr2 [1 << AW];
    logic [DW-1:0] wm2 [1 << AW];
    logic [DW-1:0] st2a, st2b;

    always @(posedge clk) begin
        st1 <= wr1[ram_addr1] ? wm1[ram_addr1] : memval(ram_addr1);
        if (ram_write1) begin
            wr1[ram_addr1] <= 1'b1;
            wm1[ram_addr1] <= ram_indata1;
        end
    end
    assign ram_outdata1 = st1;

    always @(posedge clk) begin
        st2a <= wr2[ram_addr2] ? wm2[ram_addr2] : memval(ram_addr2);
        st2b <= st2a;
        if (ram_write2) begin
            wr2[ram_addr2] <= 1'b1;
            wm2[ram_addr2] <= ram_indata2;
        end
    end
    assign ram_outdata2 = st2b;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One read-only bundle on dut2; ord holds the expected issue order, 2 bits per slot.
    task automatic read_bundle(input string tag, input logic [NR-1:0] req,
                               input logic [7:0] ord, input int n);
        logic [1:0] ch;
        rd_req = req;
        for (int c = 0; c <= n * 3; c++) begin
            @(negedge clk);
            if (c < n * 3 && c % 3 == 0) begin
                ch = ord[(c / 3) * 2 +: 2];
                check_eq({tag, "_issue"}, ram_read2, 1);
                check_eq({tag, "_addr"}, ram_addr2, chan_addr(int'(ch)));
            end else begin
                check_eq({tag, "_noissue"}, ram_read2, 0);
            end
            check_eq({tag, "_stall"}, stall2, (c < n * 3) ? 1 : 0);
            if (c == n * 3) begin
                check_eq({tag, "_ready"}, rd_ready2, req);
                for (int i = 0; i < NR; i++) begin
                    if (req[i]) check_eq({tag, "_data"}, rd_data2[i*DW +: DW], memval(chan_addr(i)));
                end
            end
            step();
        end
        rd_req = '0;
        @(negedge clk);
        check_eq({tag, "_idle"}, ram_read2, 0);
        step();
    endtask

    initial begin
        rst1 = 1'b0; rst2 = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;

        @(negedge clk);
        check_eq("rst_read", ram_read1, 0);
        check_eq("rst_write", ram_write1, 0);
        check_eq("rst_addr", ram_addr1, 0);
        check_eq("rst_rdy", rd_ready1, 0);
        check_eq("rst_wrdy", wr_ready1, 0);
        check_eq("rst_stall", stall1, 0);
        check_eq("rst_data", rd_data1, 0);

        // single read, RAM_LAT=1
        step();
        rst1 = 1'b1;
        rd_req = 4'b0001;
        rd_addr[0 +: AW] = 14'h0040;
        @(negedge clk);
        check_eq("r1_c0_read", ram_read1, 1);
        check_eq("r1_c0_addr", ram_addr1, 14'h0040);
        check_eq("r1_c0_stall", stall1, 1);
        step(); @(negedge clk);
        check_eq("r1_c1_read", ram_read1, 0);
        check_eq("r1_c1_stall", stall1, 1);
        check_eq("r1_c1_rdy", rd_ready1, 0);
        step(); @(negedge clk);
        check_eq("r1_c2_rdy", rd_ready1, 4'b0001);
        check_eq("r1_c2_data", rd_data1[0 +: DW], 10'h2A5);
        check_eq("r1_c2_stall", stall1, 0);
        step(); @(negedge clk);
        check_eq("r1_c3_flags_clear", rd_ready1, 0);
        check_eq("r1_c3_new_bundle", ram_read1, 1);
        step();
        rd_req = '0;
        @(negedge clk);
        check_eq("r1_c4_stall", stall1, 0);
        step(); @(negedge clk);
        check_eq("r1_c5_rdy", rd_ready1, 0);
        check_eq("r1_c5_data", rd_data1[0 +: DW], 10'h2A5);
        step(); step();

        // write then read of the same address
        wr_req = 1'b1; wr_addr = 14'h0100; wr_data = 10'h155;
        rd_req = 4'b0100;
        rd_addr[2*AW +: AW] = 14'h0100;
        @(negedge clk);
        check_eq("wr_c0_write", ram_write1, 1);
        check_eq("wr_c0_read", ram_read1, 0);
        check_eq("wr_c0_addr", ram_addr1, 14'h0100);
        check_eq("wr_c0_indata", ram_indata1, 10'h155);
        check_eq("wr_c0_wrdy", wr_ready1, 0);
        check_eq("wr_c0_stall", stall1, 1);
        step(); @(negedge clk);
        check_eq("wr_c1_wrdy", wr_ready1, 1);
        check_eq("wr_c1_write", ram_write1, 0);
        check_eq("wr_c1_read", ram_read1, 1);
        check_eq("wr_c1_addr", ram_addr1, 14'h0100);
        step(); @(negedge clk);
        check_eq("wr_c2_stall", stall1, 1);
        step(); @(negedge clk);
        check_eq("wr_c3_stall", stall1, 0);
        check_eq("wr_c3_rdy", rd_ready1, 4'b0100);
        check_eq("wr_c3_data", rd_data1[2*DW +: DW], 10'h155);
        check_eq("wr_c3_wrdy", wr_ready1, 1);
        step();
        wr_req = 1'b0; rd_req = '0; rst1 = 1'b0;

        // dut2, RAM_LAT=2
        for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = chan_addr(i);
        step();
        rst2 = 1'b1;
        read_bundle("four", 4'b1111, 8'hE4, 4);    // order 0,1,2,3
        read_bundle("ptr0", 4'b0011, 8'h04, 2);    // order 0,1 -> pointer wrapped to 0
        read_bundle("fair", 4'b1111, 8'h4E, 4);    // order 2,3,0,1
        read_bundle("one",  4'b0001, 8'h00, 1);    // leaves pointer at 1

        // abort: channel 1 drops its request while its read is in flight
        rd_addr[1*AW +: AW] = 14'h0300;
        rd_req = 4'b0110;
        @(negedge clk);
        check_eq("ab_c0_read", ram_read2, 1);
        check_eq("ab_c0_addr", ram_addr2, 14'h0300);
        step();
        rd_req = 4'b0100;
        @(negedge clk);
        check_eq("ab_c1_read", ram_read2, 0);
        check_eq("ab_c1_hold", ram_addr2, 14'h0300);
        check_eq("ab_c1_stall", stall2, 1);
        step(); step(); @(negedge clk);
        check_eq("ab_c3_read", ram_read2, 1);
        check_eq("ab_c3_addr", ram_addr2, chan_addr(2));
        step(); step(); step(); @(negedge clk);
        check_eq("ab_c6_rdy", rd_ready2, 4'b0100);
        check_eq("ab_c6_stall", stall2, 0);
        check_eq("ab_c6_data1", rd_data2[1*DW +: DW], memval(chan_addr(1)));
        check_eq("ab_c6_data2", rd_data2[2*DW +: DW], memval(chan_addr(2)));
        step();
        rd_req = '0;
        rd_addr[1*AW +: AW] = chan_addr(1);
        step();

        // reset while a read is in WAIT
        rd_req = 4'b0001;
        @(negedge clk);
        check_eq("rw_c0_read", ram_read2, 1);
        step();
        rst2 = 1'b0;
        @(negedge clk);
        check_eq("rw_c1_read", ram_read2, 0);
        step(); @(negedge clk);
        check_eq("rw_c2_read", ram_read2, 0);
        check_eq("rw_c2_write", ram_write2, 0);
        check_eq("rw_c2_addr", ram_addr2, 0);
        check_eq("rw_c2_rdy", rd_ready2, 0);
        check_eq("rw_c2_wrdy", wr_ready2, 0);
        check_eq("rw_c2_data", rd_data2, 0);
        check_eq("rw_c2_stall", stall2, 1);
        step();
        rst2 = 1'b1;
        @(negedge clk);
        check_eq("rw_c3_read", ram_read2, 1);
        check_eq("rw_c3_addr", ram_addr2, chan_addr(0));
        step(); step(); step(); @(negedge clk);
        check_eq("rw_c6_rdy", rd_ready2, 4'b0001);
        check_eq("rw_c6_data", rd_data2[0 +: DW], memval(chan_addr(0)));
        check_eq("rw_c6_stall", stall2, 0);
        step();
        rd_req = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
